// File: rtl/alu_gen_pkg.sv
// Shared types and constants for the pipelined bitwise ALU.
// The match table index is {mode_b, op}. Default match values are 8-bit and are resized at the use site.
package alu_gen_pkg;

  typedef logic [2:0] op_idx_t;

  localparam logic [1:0] OPA_AND  = 2'd0;
  localparam logic [1:0] OPA_NAND = 2'd1;
  localparam logic [1:0] OPA_OR   = 2'd2;
  localparam logic [1:0] OPA_XOR  = 2'd3;

  localparam logic [1:0] OPB_XNOR = 2'd0;
  localparam logic [1:0] OPB_AND  = 2'd1;
  localparam logic [1:0] OPB_NOR  = 2'd2;
  localparam logic [1:0] OPB_OR   = 2'd3;

  // Element [i] is the default for index i: A ops are 0..3, B ops are 4..7.
  localparam logic [7:0][7:0] MATCH_DEFAULT = {
    8'hFF, 8'hF5, 8'hF4, 8'hF1,
    8'h83, 8'hF8, 8'h00, 8'hFF
  };

  function automatic logic [7:0] match_default(input op_idx_t idx);
    return MATCH_DEFAULT[idx];
  endfunction

endpackage

// File: rtl/alu_gen_logic.sv
// Combinational op unit that selects one of eight bitwise functions by {mode_b, op}.
// It has zero latency and no flow control.
module alu_gen_logic
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_idx_t          idx,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    if (!idx[2]) begin
      case (idx[1:0])
        OPA_AND:  result = a & b;
        OPA_NAND: result = ~(a & b);
        OPA_OR:   result = a | b;
        OPA_XOR:  result = a ^ b;
        default:  result = '0;
      endcase
    end else begin
      case (idx[1:0])
        OPB_XNOR: result = ~(a ^ b);
        OPB_AND:  result = a & b;
        OPB_NOR:  result = ~(a | b);
        OPB_OR:   result = a | b;
        default:  result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_gen.sv
// Two-stage bitwise ALU with a programmable match table and a sticky interrupt with a saturating hit count.
// Latency is 2 cycles from issue to result and irq. One issue per cycle is accepted and there is no back-pressure.
module alu_gen
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             alu_clk,
  input  logic             rst_n,
  input  logic             alu_enable,
  input  logic             alu_enable_a,
  input  logic             alu_enable_b,
  input  logic [1:0]       alu_op_a,
  input  logic [1:0]       alu_op_b,
  input  logic [WIDTH-1:0] alu_in_a,
  input  logic [WIDTH-1:0] alu_in_b,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             alu_irq_clr,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_out_valid,
  output logic             alu_irq,
  output logic [2:0]       alu_irq_src,
  output logic [CNT_W-1:0] alu_irq_cnt,
  output logic             alu_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             issue;
  logic             sel_err;
  logic             s1_vld;
  op_idx_t          s1_idx;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] match_tbl [8];
  logic             hit;

  assign issue   = alu_enable & (alu_enable_a ^ alu_enable_b);
  assign sel_err = alu_enable & alu_enable_a & alu_enable_b;

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
      alu_err <= 1'b0;
    end else begin
      s1_vld  <= issue;
      alu_err <= sel_err;
      if (issue) begin
        s1_idx <= {alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a};
        s1_a   <= alu_in_a;
        s1_b   <= alu_in_b;
      end
    end
  end

  alu_gen_logic #(.WIDTH(WIDTH)) u_logic (
    .idx    (s1_idx),
    .a      (s1_a),
    .b      (s1_b),
    .result (result)
  );

  // The compare reads the registered table, so a same-cycle cfg write only affects later compares.
  assign hit = s1_vld && (result == match_tbl[s1_idx]);

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out       <= '0;
      alu_out_valid <= 1'b0;
    end else begin
      alu_out_valid <= s1_vld;
      if (s1_vld) alu_out <= result;
    end
  end

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) match_tbl[i] <= WIDTH'(match_default(op_idx_t'(i)));
    end else if (cfg_we) begin
      match_tbl[cfg_addr] <= cfg_data;
    end
  end

  // A hit in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_irq     <= 1'b0;
      alu_irq_src <= '0;
      alu_irq_cnt <= '0;
    end else if (hit) begin
      alu_irq     <= 1'b1;
      alu_irq_src <= s1_idx;
      if (alu_irq_clr)                alu_irq_cnt <= CNT_W'(1);
      else if (alu_irq_cnt != CNT_MAX) alu_irq_cnt <= alu_irq_cnt + CNT_W'(1);
    end else if (alu_irq_clr) begin
      alu_irq     <= 1'b0;
      alu_irq_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_alu_gen.sv
// Scoreboard bench for alu_gen: a wide-counter instance and a 2-bit-counter instance share the same stimulus.
// Expected results are queued at issue and popped by a monitor on every valid pulse.
module tb_alu_gen;

  logic       alu_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_enable = 1'b0, alu_enable_a = 1'b0, alu_enable_b = 1'b0;
  logic [1:0] alu_op_a = '0, alu_op_b = '0;
  logic [7:0] alu_in_a = '0, alu_in_b = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       alu_irq_clr = 1'b0;

  logic [7:0] alu_out;
  logic       alu_out_valid, alu_irq, alu_err;
  logic [2:0] alu_irq_src;
  logic [7:0] alu_irq_cnt;

  logic [7:0] sat_out;
  logic       sat_vld, sat_irq, sat_err;
  logic [2:0] sat_src;
  logic [1:0] sat_cnt;

  typedef struct packed {
    logic [7:0] out;
    logic       irq;
    logic [2:0] src;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  always #5 alu_clk = ~alu_clk;

  alu_gen #(.WIDTH(8), .CNT_W(8)) dut (
    .alu_clk(alu_clk), .rst_n(rst_n), .alu_enable(alu_enable),
    .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .alu_irq_clr(alu_irq_clr),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid), .alu_irq(alu_irq),
    .alu_irq_src(alu_irq_src), .alu_irq_cnt(alu_irq_cnt), .alu_err(alu_err)
  );

  alu_gen #(.WIDTH(8), .CNT_W(2)) u_sat (
    .alu_clk(alu_clk), .rst_n(rst_n), .alu_enable(alu_enable),
    .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .alu_irq_clr(alu_irq_clr),
    .alu_out(sat_out), .alu_out_valid(sat_vld), .alu_irq(sat_irq),
    .alu_irq_src(sat_src), .alu_irq_cnt(sat_cnt), .alu_err(sat_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge alu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_enable = 1'b0; alu_enable_a = 1'b0; alu_enable_b = 1'b0;
    cfg_we = 1'b0; alu_irq_clr = 1'b0;
  endtask

  task automatic issue(input bit mb, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input exp_t e);
    alu_enable = 1'b1; alu_enable_a = !mb; alu_enable_b = mb;
    if (mb) alu_op_b = op; else alu_op_a = op;
    alu_in_a = a; alu_in_b = b;
    q.push_back(e);
    tick();
  endtask

  always @(negedge alu_clk) begin
    if (alu_out_valid || sat_vld) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got valid=%0b/%0b out=%0h expected no valid at %0t",
                 alu_out_valid, sat_vld, alu_out, $time);
      end else begin
        mon_e = q.pop_front();
        chk("out",     alu_out,     mon_e.out);
        chk("sat_out", sat_out,     mon_e.out);
        chk("sat_vld", sat_vld,     1);
        chk("irq",     alu_irq,     mon_e.irq);
        chk("src",     alu_irq_src, mon_e.src);
        chk("sat_src", sat_src,     mon_e.src);
        chk("cnt",     alu_irq_cnt, mon_e.cnt);
        chk("sat_cnt", sat_cnt,     mon_e.cnt2);
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_out", alu_out, 0);     chk("rst_vld", alu_out_valid, 0);
    chk("rst_irq", alu_irq, 0);     chk("rst_src", alu_irq_src, 0);
    chk("rst_cnt", alu_irq_cnt, 0); chk("rst_err", alu_err, 0);
    rst_n = 1'b1;
    tick();

    // Mode A AND, with latency checked at N+1
    issue(0, 2'd0, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 3'd0, 8'd1, 2'd1});
    idle_inputs();
    chk("lat_vld_n1", alu_out_valid, 0);
    chk("lat_err_n1", alu_err, 0);
    tick(); tick();

    // Three back-to-back NOR hits, clear coinciding with the third compare
    issue(1, 2'd2, 8'h0A, 8'h00, '{8'hF5, 1'b1, 3'd6, 8'd2, 2'd2});
    issue(1, 2'd2, 8'h0A, 8'h00, '{8'hF5, 1'b1, 3'd6, 8'd3, 2'd3});
    issue(1, 2'd2, 8'h0A, 8'h00, '{8'hF5, 1'b1, 3'd6, 8'd1, 2'd1});
    idle_inputs();
    alu_irq_clr = 1'b1;
    tick();
    alu_irq_clr = 1'b0;
    tick(); tick();
    alu_irq_clr = 1'b1;
    tick();
    alu_irq_clr = 1'b0;
    chk("clr_irq", alu_irq, 0); chk("clr_cnt", alu_irq_cnt, 0); chk("clr_src", alu_irq_src, 6);

    // Table write lands on the first compare cycle; only the second issue sees 5A
    issue(0, 2'd3, 8'h50, 8'h0A, '{8'h5A, 1'b0, 3'd6, 8'd0, 2'd0});
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 8'h5A;
    issue(0, 2'd3, 8'h50, 8'h0A, '{8'h5A, 1'b1, 3'd3, 8'd1, 2'd1});
    idle_inputs();
    tick(); tick();

    // Illegal select pulses err, produces no result and leaves alu_out alone
    alu_enable = 1'b1; alu_enable_a = 1'b1; alu_enable_b = 1'b1;
    alu_in_a = 8'h11; alu_in_b = 8'h22;
    tick();
    idle_inputs();
    chk("err_pulse", alu_err, 1); chk("sat_err", sat_err, 1); chk("err_out", alu_out, 8'h5A);
    tick();
    chk("err_gone", alu_err, 0); chk("err_noval", alu_out_valid, 0);
    alu_enable_a = 1'b1;
    tick();
    alu_enable = 1'b1; alu_enable_a = 1'b0;
    tick();
    idle_inputs();
    chk("idle_noerr", alu_err, 0);
    tick(); tick();
    chk("idle_out", alu_out, 8'h5A);

    // Five hits: the 2-bit counter saturates at 3
    issue(0, 2'd0, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 3'd0, 8'd2, 2'd2});
    issue(0, 2'd0, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 3'd0, 8'd3, 2'd3});
    issue(0, 2'd0, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 3'd0, 8'd4, 2'd3});
    issue(0, 2'd0, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 3'd0, 8'd5, 2'd3});
    issue(0, 2'd0, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 3'd0, 8'd6, 2'd3});
    idle_inputs();
    tick(); tick();
    alu_irq_clr = 1'b1;
    tick();
    alu_irq_clr = 1'b0;
    chk("sat_clr_cnt", sat_cnt, 0); chk("sat_clr_irq", sat_irq, 0);
    chk("clr2_cnt", alu_irq_cnt, 0);

    // Reset while an issue sits in stage 1
    issue(0, 2'd1, 8'hF0, 8'h0F, '{8'hFF, 1'b0, 3'd0, 8'd0, 2'd0});
    void'(q.pop_back());
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", alu_out, 0); chk("mid_rst_vld", alu_out_valid, 0);
    chk("mid_rst_irq", alu_irq, 0); chk("mid_rst_src", alu_irq_src, 0);
    chk("mid_rst_cnt", alu_irq_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Table back at defaults: 5A no longer hits index 3, 83 does
    issue(0, 2'd3, 8'h50, 8'h0A, '{8'h5A, 1'b0, 3'd0, 8'd0, 2'd0});
    issue(0, 2'd3, 8'h80, 8'h03, '{8'h83, 1'b1, 3'd3, 8'd1, 2'd1});
    // Remaining ops against their defaults
    issue(1, 2'd0, 8'h0F, 8'h0E, '{8'hFE, 1'b1, 3'd3, 8'd1, 2'd1});
    issue(1, 2'd1, 8'hF4, 8'hFF, '{8'hF4, 1'b1, 3'd5, 8'd2, 2'd2});
    issue(1, 2'd3, 8'hF0, 8'h0F, '{8'hFF, 1'b1, 3'd7, 8'd3, 2'd3});
    issue(0, 2'd2, 8'hF0, 8'h08, '{8'hF8, 1'b1, 3'd2, 8'd4, 2'd3});
    issue(0, 2'd1, 8'hF0, 8'h0F, '{8'hFF, 1'b1, 3'd2, 8'd4, 2'd3});
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
